// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART constants and the 2-of-3 vote used by the sample filter.
package uart_rx_pkg;
  localparam int UART_DATA_BITS = 8;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_synchronizer.sv
// synchronizer: generic 2-flop synchronizer for one asynchronous input, with a parameterised reset value.
module synchronizer #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver feeding a single-entry AXI-Stream byte buffer.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       m_axis_ready,
  output logic       m_axis_valid,
  output logic [7:0] m_axis_data,
  output logic       overflow,
  output logic       frame_error
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int CW = $clog2(DIVISOR);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int MIN_DIV = 8;
`else
  localparam int MIN_DIV = 4;
`endif
  if (DIVISOR < MIN_DIV) begin : g_bad_divisor
    $error("uart_rx: DIVISOR %0d below minimum %0d", DIVISOR, MIN_DIV);
  end
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [UART_DATA_BITS-1:0] sh;
  logic rx_s, tick, smp, deliver;
  synchronizer #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign tick = cnt == '0;
`ifdef UART_RX_MAJORITY_EN
  // The counter steps by one every cycle, so the last two rx_s values are those at counts 2 and 1.
  logic [1:0] hist;
  always_ff @(posedge clk) hist <= {hist[0], rx_s};
  assign smp = maj3(hist[1], hist[0], rx_s);
`else
  assign smp = rx_s;
`endif
  assign deliver = state == STOP && tick && smp;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = rx_s ? IDLE : START;
      START:   state_d = !tick ? START : smp ? IDLE : DATA;
      DATA:    state_d = tick && idx == IW'(UART_DATA_BITS - 1) ? STOP : DATA;
      STOP:    state_d = !tick ? STOP : smp ? IDLE : BREAK;
      BREAK:   state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      m_axis_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= state == IDLE ? HALF : tick ? FULL : cnt - CW'(1);
      idx          <= state == DATA && tick ? idx + IW'(1) : state == DATA ? idx : '0;
      m_axis_valid <= deliver | (m_axis_valid & ~m_axis_ready);
      overflow     <= deliver & m_axis_valid & ~m_axis_ready;
      frame_error  <= state == STOP && tick && !smp;
    end
  end
  always_ff @(posedge clk) begin
    if (state == DATA && tick) sh <= {smp, sh[UART_DATA_BITS-1:1]};
    if (deliver && (!m_axis_valid || m_axis_ready)) m_axis_data <= sh;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a queue scoreboard checking delivered bytes and rx-fall to valid latency.
module tb_uart_rx;
  localparam int DIV = 16;
  localparam int LAT = 155;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
  typedef struct {
    logic [7:0] d;
    int due;
  } exp_t;
  logic clk = 0, rst_n = 0, rx = 1, ready = 1;
  logic valid, ovf, fe, vprev = 0;
  logic [7:0] data;
  int checks = 0, errors = 0, cyc = 0, ovf_cnt = 0, fe_cnt = 0;
  exp_t q[$];

  uart_rx #(.DIVISOR(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_axis_ready(ready),
    .m_axis_valid(valid), .m_axis_data(data), .overflow(ovf), .frame_error(fe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !vprev) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency_cycle", cyc, q[0].due);
      end
      if (valid && ready) begin
        if (q.size() == 0) chk("unexpected_handshake", 1, 0);
        else begin
          chk("rx_byte", data, q[0].d);
          void'(q.pop_front());
        end
      end
      if (ovf) ovf_cnt++;
      if (fe) fe_cnt++;
    end
    vprev = valid;
  end

  task automatic tk(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e, input bit push,
                      input int stop_low, input int glitch);
    rx = 0;
    if (push) q.push_back('{e, cyc + LAT});
    tk(DIV);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < DIV; c++) begin
        rx = (i == glitch && c == DIV / 2) ? 1'b1 : b[i];
        tk();
      end
    rx = 0;
    tk(stop_low);
    rx = 1;
    tk(DIV);
  endtask

  initial begin
    tk(3);
    chk("reset_valid", valid, 0);
    chk("reset_overflow", ovf, 0);
    chk("reset_frame_error", fe, 0);
    rst_n = 1;
    tk(5);
    send(8'h55, 8'h55, 1, 0, -1);
    chk("valid_drop_after_hs", valid, 0);
    rx = 0;
    tk(4);
    rx = 1;
    tk(40);
    chk("false_start_valid", valid, 0);
    chk("false_start_fe", fe_cnt, 0);
    send(8'h99, 8'h99, 1, 0, -1);
    send(8'hC3, 8'hC3, 0, 40, -1);
    chk("frame_error_pulses", fe_cnt, 1);
    chk("frame_error_valid", valid, 0);
    tk(20);
    send(8'h12, 8'h12, 1, 0, -1);
    ready = 0;
    send(8'hA5, 8'hA5, 1, 0, -1);
    send(8'h3C, 8'h3C, 0, 0, -1);
    chk("overflow_pulses", ovf_cnt, 1);
    chk("overflow_valid_held", valid, 1);
    chk("overflow_data_held", data, 8'hA5);
    ready = 1;
    tk(3);
    chk("overflow_valid_drop", valid, 0);
    ready = 0;
    send(8'h5A, 8'h5A, 1, 0, -1);
    chk("pre_reset_valid", valid, 1);
    rx = 0;
    tk(DIV);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h6B >> i);
      tk(DIV);
    end
    rx = 1'(8'h6B >> 3);
    tk(DIV / 2);
    rst_n = 0;
    #1;
    chk("async_reset_valid", valid, 0);
    q.delete();
    rx = 1;
    tk(3);
    rst_n = 1;
    ready = 1;
    tk(5);
    send(8'h7E, 8'h7E, 1, 0, -1);
    send(8'h00, GLITCH_EXP, 1, 0, 2);
    tk(5);
    chk("scoreboard_empty", q.size(), 0);
    chk("final_overflow_count", ovf_cnt, 1);
    chk("final_frame_error_count", fe_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
